dmem_responder: RTL

Data-memory responder for the pipeline's memory stage. Accepts one load or store request at a time (address from the ALU result, store data from busB, size from dsize, sign mode from loadext), holds the pipeline with `stall` for a fixed latency, and returns one response pulse. Load data comes back already lane-selected and extended, ready for the write-back mux. It is the responding end of the memory-stage access handshake and replaces the zero-latency data memory behind the memory stage.

---
 rtl/dmem_pkg.sv | 77 +++++++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and byte-lane helpers for the memory-stage data responder.
// Lanes are big-endian: byte offset 0 lives in bits [31:24].
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    typedef struct packed {
        logic        write;
        logic [1:0]  off;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sext;
        logic        err;
    } req_t;

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b1000 >> off;
            SZ_HALF: be = off[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the low-order store bytes so every candidate lane carries them.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{wdata[7:0]}};
            SZ_HALF: lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: r = {{24{sext & b[7]}}, b};
            SZ_HALF: r = {{16{sext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic access_error(input logic [1:0] size, input logic [31:0] addr,
                                          input int unsigned depth_words);
        logic bad;
        bad = (size == SZ_ILL)
            | ((size == SZ_HALF) & addr[0])
            | ((size == SZ_WORD) & (addr[1:0] != 2'b00))
            | ({2'b00, addr[31:2]} >= 32'(depth_words));
        return bad;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
// Byte enable bit 3 controls bits [31:24].
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clock,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // NOTE: the storage array has no reset; clearing it would turn the RAM into flops and
    // reset must leave memory contents intact anyway.
    always_ff @(posedge clock) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data responder: holds the pipeline for a fixed latency per access and
// returns one response pulse with lane-selected, extended load data.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    req_t          req_q, req_d;
    logic [AW-1:0] idx_q, idx_d;

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          resp_active;

    // NOTE: combinational logic uses blocking assignments with every output defaulted first,
    // so no path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        idx_d   = idx_q;
        ram_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.write = req_write;
                    req_d.off   = req_addr[1:0];
                    req_d.wdata = req_wdata;
                    req_d.size  = req_size;
                    req_d.sext  = req_signed;
                    req_d.err   = access_error(req_size, req_addr, DEPTH_WORDS);
                    idx_d       = req_addr[AW+1:2];
                    cnt_d       = 4'(LATENCY - 1);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    // A reset in this cycle drops the access before its write edge.
                    ram_en  = reset & ~req_q.err;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values; the reset is synchronous and active-low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
        end
    end

    assign ram_we    = (ram_en & req_q.write) ? byte_enable(req_q.size, req_q.off) : 4'b0000;
    assign ram_wdata = store_lanes(req_q.size, req_q.wdata);

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clock(clock),
        .en   (ram_en),
        .we   (ram_we),
        .addr (idx_q),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign resp_active = reset & (state_q == RESP);
    assign resp_valid  = resp_active;
    assign resp_err    = resp_active & req_q.err;
    assign resp_rdata  = (resp_active & ~req_q.err & ~req_q.write)
                       ? load_extend(ram_rdata, req_q.size, req_q.off, req_q.sext)
                       : 32'h0;
    assign stall       = reset & (((state_q == IDLE) & req_valid) | (state_q == BUSY));

endmodule
